// File: rtl/instr_seq_pkg.sv
// Shared encodings for the MSP430 instruction sequencer: states, MAB mux codes,
// instruction formats, opcode fields and the addressing-mode classification record.
package instr_seq_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StSrcExt = 4'd1,
    StSrcRd  = 4'd2,
    StDstExt = 4'd3,
    StDstRd  = 4'd4,
    StExec   = 4'd5,
    StWbMem  = 4'd6,
    StTrap   = 4'd7
  } seq_state_e;

  localparam logic [2:0] MAB_PC   = 3'd0;
  localparam logic [2:0] MAB_SOUT = 3'd1;
  localparam logic [2:0] MAB_CALC = 3'd2;
  localparam logic [2:0] MAB_MDB  = 3'd3;

  typedef enum logic [1:0] {
    FmtJump = 2'd0,
    FmtI    = 2'd1,
    FmtII   = 2'd2,
    FmtBad  = 2'd3
  } fmt_e;

  localparam logic [2:0] OP_JUMP     = 3'b001;
  localparam logic [3:0] OP_FMT2     = 4'h1;
  localparam logic [3:0] OP_FMT1_MIN = 4'h4;
  localparam logic [3:0] OP_CMP      = 4'h9;
  localparam logic [3:0] OP_BIT      = 4'hB;
  localparam logic [2:0] OP2_PUSH    = 3'b100;
  localparam logic [2:0] OP2_CALL    = 3'b101;
  localparam logic [2:0] OP2_RETI    = 3'b110;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  typedef struct packed {
    logic       illegal;
    logic       need_sext;
    logic       imm;
    logic       need_srd;
    logic       need_dext;
    logic       need_wb;
    logic       reg_wr;
    logic       ai_inc;
    logic [1:0] ai_step;
  } cls_t;

endpackage

// File: rtl/addr_mode_cls.sv
// Combinational classifier: maps an instruction word to the phases it needs
// (extension words, operand reads, write-back) and its execute-cycle controls.
module addr_mode_cls
  import instr_seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output cls_t        cls_o
);

  fmt_e       fmt;
  logic [3:0] op, sa;
  logic [1:0] as_m;
  logic       ad, bw;
  logic       is_fmt1, is_fmt2, fmt2_trap, operand;
  logic       is_const, imm, src_mem, cmp_bit;

  always_comb begin
    if (ir_i[15:13] == OP_JUMP)          fmt = FmtJump;
    else if (ir_i[15:12] == OP_FMT2)     fmt = FmtII;
    else if (ir_i[15:12] >= OP_FMT1_MIN) fmt = FmtI;
    else                                 fmt = FmtBad;
  end

  assign op        = ir_i[15:12];
  assign as_m      = ir_i[5:4];
  assign ad        = ir_i[7];
  assign bw        = ir_i[6];
  assign is_fmt1   = (fmt == FmtI);
  assign is_fmt2   = (fmt == FmtII);
  assign fmt2_trap = is_fmt2 && (ir_i[9:7] inside {OP2_PUSH, OP2_CALL, OP2_RETI});
  assign operand   = is_fmt1 || (is_fmt2 && !fmt2_trap);
  assign sa        = is_fmt1 ? ir_i[11:8] : ir_i[3:0];

  // Constant generator: R3 in any mode, R2 in the two indirect modes.
  assign is_const = (sa == REG_CG) || ((sa == REG_SR) && as_m[1]);
  assign imm      = (as_m == 2'b11) && (sa == REG_PC);
  assign src_mem  = (as_m != 2'b00) && !is_const && !imm;
  assign cmp_bit  = (op == OP_CMP) || (op == OP_BIT);

  always_comb begin
    cls_o           = '0;
    cls_o.illegal   = (fmt == FmtBad) || fmt2_trap;
    cls_o.need_sext = operand && (((as_m == 2'b01) && !is_const) || imm);
    cls_o.imm       = operand && imm;
    cls_o.need_srd  = operand && src_mem;
    cls_o.need_dext = is_fmt1 && ad;
    cls_o.need_wb   = is_fmt1 ? (ad && !cmp_bit) : (operand && src_mem);
    cls_o.reg_wr    = is_fmt1 ? (!ad && !cmp_bit) : (operand && (as_m == 2'b00));
    cls_o.ai_inc    = operand && (as_m == 2'b11) && src_mem;
    if (operand) cls_o.ai_step = (bw && (sa > REG_SP)) ? 2'd1 : 2'd2;
  end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle MSP430 instruction sequencer: owns the IR and walks fetch, extension,
// operand-read, execute and write-back phases, emitting datapath strobes.
module instr_seq
  import instr_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MDB_out,
  input  logic        mem_rdy,
  output logic [15:0] IR,
  output logic        IR_ld,
  output logic        PC_inc,
  output logic [2:0]  MAB_sel,
  output logic        SRC_ld,
  output logic        DST_ld,
  output logic        SEXT_ld,
  output logic        DEXT_ld,
  output logic        EXEC,
  output logic        RW,
  output logic        MW,
  output logic        AI_inc,
  output logic [1:0]  AI_step,
  output logic        instr_done,
  output logic        illegal,
  output logic [3:0]  state
);

  seq_state_e  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] cls_ir;
  cls_t        cls;

  // In FETCH the word on the bus is classified so the next state is known at once.
  assign cls_ir = (state_q == StFetch) ? MDB_out : ir_q;

  addr_mode_cls u_cls (
    .ir_i  (cls_ir),
    .cls_o (cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign IR    = ir_q;
  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    IR_ld      = 1'b0;
    PC_inc     = 1'b0;
    MAB_sel    = MAB_PC;
    SRC_ld     = 1'b0;
    DST_ld     = 1'b0;
    SEXT_ld    = 1'b0;
    DEXT_ld    = 1'b0;
    EXEC       = 1'b0;
    RW         = 1'b0;
    MW         = 1'b0;
    AI_inc     = 1'b0;
    AI_step    = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (mem_rdy) begin
          IR_ld  = 1'b1;
          PC_inc = 1'b1;
          ir_d   = MDB_out;
          if (cls.illegal)        state_d = StTrap;
          else if (cls.need_sext) state_d = StSrcExt;
          else if (cls.need_srd)  state_d = StSrcRd;
          else if (cls.need_dext) state_d = StDstExt;
          else                    state_d = StExec;
        end
      end
      StSrcExt: begin
        if (mem_rdy) begin
          PC_inc  = 1'b1;
          SRC_ld  = cls.imm;
          SEXT_ld = !cls.imm;
          if (!cls.imm)           state_d = StSrcRd;
          else if (cls.need_dext) state_d = StDstExt;
          else                    state_d = StExec;
        end
      end
      StSrcRd: begin
        MAB_sel = (cls_ir[5:4] == 2'b01) ? MAB_CALC : MAB_SOUT;
        if (mem_rdy) begin
          SRC_ld  = 1'b1;
          state_d = cls.need_dext ? StDstExt : StExec;
        end
      end
      StDstExt: begin
        if (mem_rdy) begin
          PC_inc  = 1'b1;
          DEXT_ld = 1'b1;
          state_d = StDstRd;
        end
      end
      StDstRd: begin
        MAB_sel = MAB_CALC;
        if (mem_rdy) begin
          DST_ld  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        EXEC       = 1'b1;
        RW         = cls.reg_wr;
        AI_inc     = cls.ai_inc;
        AI_step    = cls.ai_step;
        instr_done = !cls.need_wb;
        state_d    = cls.need_wb ? StWbMem : StFetch;
      end
      StWbMem: begin
        MAB_sel = MAB_CALC;
        if (mem_rdy) begin
          MW         = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
      end
      StTrap: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = StTrap;
      end
    endcase

    // Reset suppresses every strobe in the reset cycle, including an in-flight MW.
    if (rst) begin
      IR_ld      = 1'b0;
      PC_inc     = 1'b0;
      MAB_sel    = MAB_PC;
      SRC_ld     = 1'b0;
      DST_ld     = 1'b0;
      SEXT_ld    = 1'b0;
      DEXT_ld    = 1'b0;
      EXEC       = 1'b0;
      RW         = 1'b0;
      MW         = 1'b0;
      AI_inc     = 1'b0;
      AI_step    = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: directed instruction scenarios plus random
// instructions and wait states against a phase-list reference model.
module tb_instr_seq;
  import instr_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MDB_out;
  logic        mem_rdy;
  logic [15:0] IR;
  logic        IR_ld, PC_inc, SRC_ld, DST_ld, SEXT_ld, DEXT_ld;
  logic        EXEC, RW, MW, AI_inc, instr_done, illegal;
  logic [2:0]  MAB_sel;
  logic [1:0]  AI_step;
  logic [3:0]  state;

  instr_seq dut (
    .clk        (clk),
    .rst        (rst),
    .MDB_out    (MDB_out),
    .mem_rdy    (mem_rdy),
    .IR         (IR),
    .IR_ld      (IR_ld),
    .PC_inc     (PC_inc),
    .MAB_sel    (MAB_sel),
    .SRC_ld     (SRC_ld),
    .DST_ld     (DST_ld),
    .SEXT_ld    (SEXT_ld),
    .DEXT_ld    (DEXT_ld),
    .EXEC       (EXEC),
    .RW         (RW),
    .MW         (MW),
    .AI_inc     (AI_inc),
    .AI_step    (AI_step),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] mab;
    logic       ir_ld, pc_inc, src_ld, dst_ld, sext_ld, dext_ld;
    logic       exe, rw, mw, ai_inc;
    logic [1:0] ai_step;
    logic       done, ill;
  } obs_t;

  obs_t        obs;
  obs_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_ir = 16'h0000;

  assign obs = {state, MAB_sel, IR_ld, PC_inc, SRC_ld, DST_ld, SEXT_ld, DEXT_ld,
                EXEC, RW, MW, AI_inc, AI_step, instr_done, illegal};

  function automatic obs_t ph(input logic [3:0] st, input logic [2:0] mab);
    obs_t p;
    p     = '0;
    p.st  = st;
    p.mab = mab;
    return p;
  endfunction

  // Reference: the list of phases an instruction walks through, one entry per
  // mem_rdy-completed cycle, derived from the instruction fields.
  function automatic void build_phases(input logic [15:0] ir);
    logic [3:0] op, sa;
    logic [1:0] am;
    logic       jump, f1, f2, bad, cg, imm, srcmem, cmpbit, wb;
    obs_t       p;
    exp_q.delete();
    op     = ir[15:12];
    am     = ir[5:4];
    jump   = (ir[15:13] == 3'b001);
    f2     = (op == 4'h1);
    f1     = (op >= 4'h4);
    bad    = !(jump || f1 || f2) || (f2 && ir[9:7] >= 3'd4 && ir[9:7] <= 3'd6);
    sa     = f1 ? ir[11:8] : ir[3:0];
    cg     = (sa == 4'd3) || (sa == 4'd2 && am >= 2'd2);
    imm    = (am == 2'd3) && (sa == 4'd0);
    srcmem = (am != 2'd0) && !cg && !imm;
    cmpbit = f1 && (op == 4'h9 || op == 4'hB);
    wb     = 1'b0;
    p = ph(StFetch, MAB_PC); p.ir_ld = 1'b1; p.pc_inc = 1'b1; exp_q.push_back(p);
    if (bad) begin
      for (int i = 0; i < 3; i++) begin
        p = ph(StTrap, MAB_PC); p.ill = 1'b1; exp_q.push_back(p);
      end
      return;
    end
    if (!jump) begin
      if ((am == 2'd1 && !cg) || imm) begin
        p = ph(StSrcExt, MAB_PC); p.pc_inc = 1'b1;
        if (imm) p.src_ld = 1'b1; else p.sext_ld = 1'b1;
        exp_q.push_back(p);
      end
      if (srcmem) begin
        p = ph(StSrcRd, (am == 2'd1) ? MAB_CALC : MAB_SOUT); p.src_ld = 1'b1;
        exp_q.push_back(p);
      end
      if (f1 && ir[7]) begin
        p = ph(StDstExt, MAB_PC); p.pc_inc = 1'b1; p.dext_ld = 1'b1; exp_q.push_back(p);
        p = ph(StDstRd, MAB_CALC); p.dst_ld = 1'b1; exp_q.push_back(p);
      end
      wb = f1 ? (ir[7] && !cmpbit) : srcmem;
    end
    p = ph(StExec, MAB_PC); p.exe = 1'b1;
    if (!jump) begin
      p.rw      = f1 ? (!ir[7] && !cmpbit) : (am == 2'd0);
      p.ai_inc  = (am == 2'd3) && srcmem;
      p.ai_step = (ir[6] && sa > 4'd1) ? 2'd1 : 2'd2;
    end
    p.done = !wb;
    exp_q.push_back(p);
    if (wb) begin
      p = ph(StWbMem, MAB_CALC); p.mw = 1'b1; p.done = 1'b1; exp_q.push_back(p);
    end
  endfunction

  task automatic run_instr(input logic [15:0] ir, input int wait_max, input int srcrd_wait,
                           input bit rst_in_wb, output int cycles, output int n_pc,
                           output int n_rw, output int n_mw, output int n_ai);
    obs_t        e, x;
    int          w;
    logic [15:0] ir_exp;
    bit          is_mem;
    build_phases(ir);
    cycles = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_ai = 0;
    ir_exp = prev_ir;
    while (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      is_mem = !(e.st inside {StExec, StTrap});
      if (!is_mem) w = 0;
      else if (e.st == StSrcRd && srcrd_wait >= 0) w = srcrd_wait;
      else w = $urandom_range(wait_max, 0);
      if (rst_in_wb && e.st == StWbMem) begin
        @(negedge clk);
        rst = 1'b1; mem_rdy = 1'b1; MDB_out = 16'($urandom);
        #1;
        checks++;
        if (MW !== 1'b0 || instr_done !== 1'b0 || state !== StWbMem)
          begin errors++; $display("FAIL wb_abort: MW=%b done=%b state=%0d, want 0 0 %0d",
                                   MW, instr_done, state, StWbMem); end
        @(negedge clk);
        rst = 1'b0; mem_rdy = 1'b0;
        #1;
        checks++;
        if (state !== StFetch || IR !== 16'h0000)
          begin errors++; $display("FAIL wb_abort_after: state=%0d IR=%h, want %0d 0000",
                                   state, IR, StFetch); end
        prev_ir = 16'h0000;
        return;
      end
      for (int i = 0; i <= w; i++) begin
        @(negedge clk);
        mem_rdy = (i == w);
        if (e.st == StTrap) mem_rdy = 1'($urandom_range(1, 0));
        MDB_out = (e.st == StFetch && i == w) ? ir : 16'($urandom);
        #1;
        x = e;
        if (i != w) x = ph(e.st, e.mab);
        cycles++;
        n_pc += int'(PC_inc); n_rw += int'(RW); n_mw += int'(MW); n_ai += int'(AI_inc);
        checks++;
        if (obs !== x) begin
          errors++;
          $display("FAIL phase ir=%h st=%0d wait=%0d: got %h want %h", ir, e.st, i != w, obs, x);
        end
        checks++;
        if (IR !== ir_exp) begin
          errors++; $display("FAIL ir_hold ir=%h: got %h want %h", ir, IR, ir_exp);
        end
        if (e.st == StFetch && i == w) ir_exp = ir;
      end
    end
    prev_ir = ir;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; mem_rdy = 1'b0;
    @(negedge clk); rst = 1'b0;
    prev_ir = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_rdy = 1'b1; MDB_out = 16'($urandom); #1;
      checks++;
      if (obs[16:0] !== 17'd0) begin
        errors++; $display("FAIL reset_strobes: got %h want 0", obs[16:0]);
      end
    end
    @(negedge clk); rst = 1'b0; mem_rdy = 1'b0; #1;
    checks++;
    if (state !== StFetch || IR !== 16'h0000 || MAB_sel !== MAB_PC || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d IR=%h MAB=%0d ill=%b want 0 0000 0 0",
                         state, IR, MAB_sel, illegal);
    end
    prev_ir = 16'h0000;
  endtask

  task automatic test_reg_reg();
    int c, p, r, m, a;
    run_instr(16'h4405, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 2 || p != 1 || r != 1 || m != 0)
      begin errors++; $display("FAIL mov_rr: cyc=%0d pc=%0d rw=%0d mw=%0d want 2 1 1 0", c, p, r, m); end
  endtask

  task automatic test_immediate();
    int c, p, r, m, a;
    run_instr(16'h5036, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 3 || p != 2 || r != 1)
      begin errors++; $display("FAIL add_imm: cyc=%0d pc=%0d rw=%0d want 3 2 1", c, p, r); end
  endtask

  task automatic test_indexed();
    int c, p, r, m, a;
    run_instr(16'h5495, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 7 || p != 3 || r != 0 || m != 1)
      begin errors++; $display("FAIL add_idx: cyc=%0d pc=%0d rw=%0d mw=%0d want 7 3 0 1", c, p, r, m); end
  endtask

  task automatic test_cmp_autoinc();
    int c, p, r, m, a;
    run_instr(16'h9482, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 4 || r != 0 || m != 0)
      begin errors++; $display("FAIL cmp_abs: cyc=%0d rw=%0d mw=%0d want 4 0 0", c, r, m); end
    run_instr(16'h4475, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 3 || a != 1 || r != 1)
      begin errors++; $display("FAIL mov_ai: cyc=%0d ai=%0d rw=%0d want 3 1 1", c, a, r); end
  endtask

  task automatic test_wait_states();
    int c, p, r, m, a;
    run_instr(16'h4475, 0, 3, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 6 || a != 1)
      begin errors++; $display("FAIL wait_srcrd: cyc=%0d ai=%0d want 6 1", c, a); end
  endtask

  task automatic test_jump();
    int c, p, r, m, a;
    run_instr(16'h3C05, 0, -1, 1'b0, c, p, r, m, a);
    checks++;
    if (c != 2 || p != 1 || r != 0)
      begin errors++; $display("FAIL jump: cyc=%0d pc=%0d rw=%0d want 2 1 0", c, p, r); end
  endtask

  task automatic test_random();
    int          c, p, r, m, a;
    logic [15:0] ir;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(2, 0))
        0:       ir = {4'($urandom_range(15, 4)), 12'($urandom)};
        1:       ir = {6'b000100, 3'($urandom_range(3, 0)), 7'($urandom)};
        default: ir = {3'b001, 13'($urandom)};
      endcase
      run_instr(ir, 2, -1, 1'b0, c, p, r, m, a);
    end
  endtask

  task automatic test_trap();
    int c, p, r, m, a;
    run_instr(16'h0000, 1, -1, 1'b0, c, p, r, m, a);
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL trap_rst: ill=%b want 0", illegal); end
    @(negedge clk); rst = 1'b0; mem_rdy = 1'b0; #1;
    checks++;
    if (state !== StFetch) begin errors++; $display("FAIL trap_exit: st=%0d want 0", state); end
    prev_ir = 16'h0000;
    run_instr(16'h1280, 1, -1, 1'b0, c, p, r, m, a);
    do_reset();
  endtask

  task automatic test_reset_mid_wb();
    int c, p, r, m, a;
    run_instr(16'h5495, 0, -1, 1'b1, c, p, r, m, a);
    checks++;
    if (m != 0) begin errors++; $display("FAIL wb_abort_mw: mw=%0d want 0", m); end
    run_instr(16'h4405, 1, -1, 1'b0, c, p, r, m, a);
  endtask

  initial begin
    rst = 1'b1; mem_rdy = 1'b0; MDB_out = 16'h0000;
    test_reset();
    test_reg_reg();
    test_immediate();
    test_indexed();
    test_cmp_autoinc();
    test_wait_states();
    test_jump();
    test_random();
    test_trap();
    test_reset_mid_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
